// File: rtl/data_bank_array_pkg.sv
// Shared cache data-bank definitions: default geometry, FSM encoding and
// the helper locating a way's slice within the flattened response bus.
package data_bank_array_pkg;

    localparam int DEF_NUM_WAYS   = 4;
    localparam int DEF_NUM_SETS   = 64;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bank_state_e;

    // Lowest bit index of way 'way' in a flat bus of 'width'-bit slices.
    function automatic int way_lo(input int way, input int width);
        return way * width;
    endfunction

endpackage

// File: rtl/data_bank_array_bank_sram.sv
// Single-way synchronous-read SRAM with byte-masked writes.
// A read and a write to the same address in one cycle return the old data;
// the top level supplies the bypass.
module bank_sram #(
    parameter int NUM_SETS   = 64,
    parameter int DATA_WIDTH = 32,
    localparam int SET_BITS  = $clog2(NUM_SETS),
    localparam int MASK_BITS = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic [SET_BITS-1:0]   r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    input  logic                  w_en,
    input  logic [SET_BITS-1:0]   w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [MASK_BITS-1:0]  w_mask
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_SETS];
    logic [DATA_WIDTH-1:0] r_data_q;

    // Storage array: byte-masked write and registered read every cycle.
    always_ff @(posedge clock) begin
        if (w_en) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (w_mask[b]) begin
                    mem_q[w_addr][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
        r_data_q <= mem_q[r_addr];
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/data_bank_array.sv
// Multi-way cache data bank: zero-fill after reset, valid/ready request
// ports, same-set write-to-read bypass and a response hold register.
module data_bank_array
    import data_bank_array_pkg::*;
#(
    parameter int NUM_WAYS   = DEF_NUM_WAYS,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int SET_BITS  = $clog2(NUM_SETS),
    localparam int MASK_BITS = DATA_WIDTH / 8
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           io_init_done,
    input  logic                           io_w_valid,
    output logic                           io_w_ready,
    input  logic [SET_BITS-1:0]            io_w_set,
    input  logic [NUM_WAYS-1:0]            io_w_way,
    input  logic [DATA_WIDTH-1:0]          io_w_data,
    input  logic [MASK_BITS-1:0]           io_w_mask,
    input  logic                           io_r_valid,
    output logic                           io_r_ready,
    input  logic [SET_BITS-1:0]            io_r_set,
    output logic                           io_resp_valid,
    output logic [NUM_WAYS*DATA_WIDTH-1:0] io_resp_data
);

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(NUM_SETS - 1);

    bank_state_e                     state_q, state_d;
    logic [SET_BITS-1:0]             cnt_q, cnt_d;
    logic                            resp_valid_q, resp_valid_d;
    logic [NUM_WAYS*MASK_BITS-1:0]   byp_mask_q, byp_mask_d;
    logic [DATA_WIDTH-1:0]           byp_data_q, byp_data_d;
    logic [NUM_WAYS*DATA_WIDTH-1:0]  hold_q, hold_d;

    logic                            run_s;
    logic                            hit_s;
    logic [NUM_WAYS-1:0]             sram_w_en_s;
    logic [SET_BITS-1:0]             sram_w_addr_s;
    logic [DATA_WIDTH-1:0]           sram_w_data_s;
    logic [MASK_BITS-1:0]            sram_w_mask_s;
    logic [NUM_WAYS*DATA_WIDTH-1:0]  sram_r_data_s;
    logic [NUM_WAYS*DATA_WIDTH-1:0]  merged_s;

    assign run_s        = (state_q == ST_RUN);
    assign io_init_done = run_s;
    assign io_w_ready   = run_s;
    assign io_r_ready   = run_s;

    // Zero-fill sequencing: walk every set once, then stay in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + SET_BITS'(1);
                if (cnt_q == LAST_SET) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM write port: zero-fill owns it during INIT, requests own it in RUN.
    always_comb begin
        if (state_q == ST_INIT) begin
            sram_w_en_s   = '1;
            sram_w_addr_s = cnt_q;
            sram_w_data_s = '0;
            sram_w_mask_s = '1;
        end else begin
            sram_w_en_s   = io_w_valid ? io_w_way : '0;
            sram_w_addr_s = io_w_set;
            sram_w_data_s = io_w_data;
            sram_w_mask_s = io_w_mask;
        end
    end

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WAYS; gw++) begin : g_way
            bank_sram #(
                .NUM_SETS  (NUM_SETS),
                .DATA_WIDTH(DATA_WIDTH)
            ) u_sram (
                .clock (clock),
                .r_addr(io_r_set),
                .r_data(sram_r_data_s[gw*DATA_WIDTH +: DATA_WIDTH]),
                .w_en  (sram_w_en_s[gw]),
                .w_addr(sram_w_addr_s),
                .w_data(sram_w_data_s),
                .w_mask(sram_w_mask_s)
            );
        end
    endgenerate

    assign hit_s = run_s & io_w_valid & io_r_valid & (io_w_set == io_r_set);

    // Capture the read strobe and which bytes of which ways the same-cycle write overrides.
    always_comb begin
        resp_valid_d = run_s & io_r_valid;
        byp_data_d   = io_w_data;
        for (int w = 0; w < NUM_WAYS; w++) begin
            byp_mask_d[w*MASK_BITS +: MASK_BITS] = (hit_s && io_w_way[w]) ? io_w_mask : '0;
        end
    end

    // Merge SRAM read data with bypassed write bytes in the response cycle.
    always_comb begin
        merged_s = sram_r_data_s;
        for (int w = 0; w < NUM_WAYS; w++) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (byp_mask_q[w*MASK_BITS + b]) begin
                    merged_s[way_lo(w, DATA_WIDTH) + b*8 +: 8] = byp_data_q[b*8 +: 8];
                end else begin
                    merged_s[way_lo(w, DATA_WIDTH) + b*8 +: 8] =
                        sram_r_data_s[way_lo(w, DATA_WIDTH) + b*8 +: 8];
                end
            end
        end
    end

    // Response bus: fresh merge in the response cycle, held copy otherwise.
    always_comb begin
        if (resp_valid_q) begin
            hold_d       = merged_s;
            io_resp_data = merged_s;
        end else begin
            hold_d       = hold_q;
            io_resp_data = hold_q;
        end
    end

    assign io_resp_valid = resp_valid_q;

    // State, counter, bypass and hold registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            byp_mask_q   <= '0;
            byp_data_q   <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            byp_mask_q   <= byp_mask_d;
            byp_data_q   <= byp_data_d;
            hold_q       <= hold_d;
        end
    end

endmodule
